// File: rtl/uart_encoder.sv
// Frame encoder for the board-to-board link: snapshots game state and writes 8 opcode-tagged bytes to the UART TX FIFO.
// Optional build macro UART_ENC_SHOT_PRIORITY_EN: a rising is_shooted edge starts a frame early instead of waiting out the gap.
module uart_encoder #(
  parameter int GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       tx_full,
  input  logic       local_shooter,
  input  logic       game_starts,
  input  logic [9:0] keeper_pos,
  input  logic [9:0] x_shooter,
  input  logic [9:0] y_shooter,
  input  logic [2:0] score,
  input  logic       is_shooted,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       frame_done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_TC = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {GAP, SNAP, SEND} state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    idx;
  logic          snap_ls;
  logic          snap_gs;
  logic [9:0]    snap_kp;
  logic [9:0]    snap_x;
  logic [9:0]    snap_y;
  logic [2:0]    snap_score;
  logic          snap_shot;
  logic [4:0]    payload;
  logic          prio_go;
  logic          prio_pend;

`ifdef UART_ENC_SHOT_PRIORITY_EN
  logic shot_prev;
  logic shot_rise;

  assign shot_rise = is_shooted & ~shot_prev;
  assign prio_go   = shot_rise & tx_en;

  // An edge seen while a frame is in flight is remembered so the next frame follows immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      shot_prev <= 1'b0;
      prio_pend <= 1'b0;
    end else begin
      shot_prev <= is_shooted;
      if (shot_rise && state != GAP)
        prio_pend <= 1'b1;
      else if (state == SNAP)
        prio_pend <= 1'b0;
    end
  end
`else
  assign prio_go   = 1'b0;
  assign prio_pend = 1'b0;
`endif

  // Byte 0 never carries shooter=1 without game_starts, so the peer never decodes 10001.
  always_comb begin
    payload = 5'd0;
    case (idx)
      3'd0: payload = {snap_ls & snap_gs, snap_gs, 3'b001};
      3'd1: payload = snap_kp[4:0];
      3'd2: payload = snap_kp[9:5];
      3'd3: payload = snap_x[4:0];
      3'd4: payload = snap_x[9:5];
      3'd5: payload = snap_y[4:0];
      3'd6: payload = snap_y[9:5];
      3'd7: payload = {1'b0, snap_shot, snap_score};
      default: payload = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GAP;
      gap_cnt    <= '0;
      idx        <= 3'd0;
      wr_uart    <= 1'b0;
      w_data     <= 8'h00;
      frame_done <= 1'b0;
      snap_ls    <= 1'b0;
      snap_gs    <= 1'b0;
      snap_kp    <= 10'd0;
      snap_x     <= 10'd0;
      snap_y     <= 10'd0;
      snap_score <= 3'd0;
      snap_shot  <= 1'b0;
    end else begin
      wr_uart    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        GAP: begin
          if (state == GAP && prio_go && GAP_CYCLES > 0)
            state <= SNAP;
          else if (gap_cnt == GAP_TC) begin
            if (tx_en)
              state <= SNAP;
          end else
            gap_cnt <= gap_cnt + GW'(1);
        end
        SNAP: begin
          snap_ls    <= local_shooter;
          snap_gs    <= game_starts;
          snap_kp    <= keeper_pos;
          snap_x     <= x_shooter;
          snap_y     <= y_shooter;
          snap_score <= score;
          snap_shot  <= is_shooted;
          idx        <= 3'd0;
          state      <= SEND;
        end
        SEND: begin
          // idx wraps to 0 in the cycle byte 7 is written, which marks the end of the frame.
          if (wr_uart && idx == 3'd0) begin
            frame_done <= 1'b1;
            gap_cnt    <= '0;
            state      <= prio_pend ? SNAP : GAP;
          end else if (!wr_uart && !tx_full) begin
            wr_uart <= 1'b1;
            w_data  <= {payload, idx};
            idx     <= idx + 3'd1;
          end
        end
        default: state <= GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_encoder.sv
// Directed bench for uart_encoder: table of input snapshots with hand-computed frames,
// plus hand sequences for FIFO stall, mid-frame input change, mid-frame reset and tx_en drop.
module tb_uart_encoder;
  localparam int GAP = 4;
`ifdef UART_ENC_SHOT_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b1;
  logic       tx_full = 1'b0;
  logic       local_shooter = 1'b0;
  logic       game_starts = 1'b0;
  logic [9:0] keeper_pos = 10'd0;
  logic [9:0] x_shooter = 10'd0;
  logic [9:0] y_shooter = 10'd0;
  logic [2:0] score = 3'd0;
  logic       is_shooted = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  uart_encoder #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .tx_full(tx_full),
    .local_shooter(local_shooter), .game_starts(game_starts),
    .keeper_pos(keeper_pos), .x_shooter(x_shooter), .y_shooter(y_shooter),
    .score(score), .is_shooted(is_shooted),
    .wr_uart(wr_uart), .w_data(w_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ls;
    logic        gs;
    logic [9:0]  kp;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  sc;
    logic        sh;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[4];
  logic model_prev_sh = 1'b0;
  logic exp_rise = 1'b0;
  logic from_reset = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    local_shooter = v.ls;
    game_starts   = v.gs;
    keeper_pos    = v.kp;
    x_shooter     = v.x;
    y_shooter     = v.y;
    score         = v.sc;
    is_shooted    = v.sh;
    exp_rise      = PRIO && tx_en && v.sh && !model_prev_sh;
    model_prev_sh = v.sh;
  endtask

  task automatic no_writes(input string tag, input int ncyc);
    int seen = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (wr_uart) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Collects one frame sampled at negedges; *_at arguments fire after that many bytes (0 = never).
  task automatic collect(input vec_t v, input string tag, input int stall_at,
                         input int chg_at, input int rst_at, input int off_at);
    int   cyc = 0;
    int   n = 0;
    int   resume = -1;
    int   stall_wr;
    logic prev_wr = 1'b0;
    int   exp_lat;
    exp_lat = exp_rise ? 3 : (from_reset ? GAP + 2 : GAP + 1);
    from_reset = 1'b0;
    while (n < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wr_uart) begin
        check($sformatf("%s back_to_back", tag), {31'd0, prev_wr}, 0);
        if (n == 0) check($sformatf("%s first_latency", tag), cyc, exp_lat);
        if (resume >= 0) begin
          check($sformatf("%s stall_resume", tag), cyc, resume + 1);
          resume = -1;
        end
        check($sformatf("%s byte%0d", tag, n), {24'd0, w_data}, {24'd0, v.exp[63-8*n -: 8]});
        n++;
        if (n == chg_at) keeper_pos = 10'h000;
        if (n == off_at) tx_en = 1'b0;
        if (n == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          check($sformatf("%s rst_wr", tag), {31'd0, wr_uart}, 0);
          check($sformatf("%s rst_wdata", tag), {24'd0, w_data}, 0);
          check($sformatf("%s rst_done", tag), {31'd0, frame_done}, 0);
          rst = 1'b0;
          model_prev_sh = 1'b0;
          from_reset = 1'b1;
          return;
        end
        if (n == stall_at) begin
          tx_full  = 1'b1;
          stall_wr = 0;
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cyc++;
            if (wr_uart) stall_wr++;
          end
          check($sformatf("%s stall_quiet", tag), stall_wr, 0);
          tx_full = 1'b0;
          resume  = cyc;
        end
      end
      prev_wr = wr_uart;
    end
    check($sformatf("%s byte_count", tag), n, 8);
    if (n == 8) begin
      @(negedge clk);
      check($sformatf("%s frame_done", tag), {31'd0, frame_done}, 1);
      @(negedge clk);
      check($sformatf("%s frame_done_pulse", tag), {31'd0, frame_done}, 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 10'h2A5, 10'd640, 10'd480, 3'd3, 1'b1, 64'hC829_AA03_A405_7E5F};
    vecs[1] = '{1'b1, 1'b0, 10'h2A5, 10'd640, 10'd480, 3'd3, 1'b1, 64'h0829_AA03_A405_7E5F};
    vecs[2] = '{1'b0, 1'b1, 10'h3FF, 10'h000, 10'h3FF, 3'd7, 1'b0, 64'h48F9_FA03_04FD_FE3F};
    vecs[3] = '{1'b0, 1'b0, 10'h001, 10'h020, 10'h21F, 3'd5, 1'b0, 64'h0809_0203_0CFD_862F};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset wr_uart", {31'd0, wr_uart}, 0);
    check("reset w_data", {24'd0, w_data}, 0);
    check("reset frame_done", {31'd0, frame_done}, 0);
    rst = 1'b0;
    model_prev_sh = 1'b0;
    from_reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      apply(vecs[i]);
      collect(vecs[i], $sformatf("vec%0d", i), 0, 0, 0, 0);
    end

    apply(vecs[0]);
    collect(vecs[0], "stall_coherent", 3, 2, 0, 0);

    apply(vecs[0]);
    collect(vecs[0], "rst_mid", 0, 0, 5, 0);
    apply(vecs[0]);
    collect(vecs[0], "post_rst", 0, 0, 0, 0);

    apply(vecs[0]);
    collect(vecs[0], "txen_drop", 0, 0, 0, 3);
    no_writes("txen_low_idle", 30);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    no_writes("txen_low_after_rst", 30);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_encoder.md
Name: uart_encoder

Overview:
Transmit-side framer for the two-board link. It snapshots local game state (role, start flag, keeper position, shot coordinates, score, shot-ended flag) and serialises it into a fixed 8-byte frame of opcode-tagged bytes. Each byte is written into the UART TX FIFO; the peer board's UART decoder consumes the frame. Frames repeat periodically, so the receiver's link-alive timeout never expires while the link is up.

Parameters:
GAP_CYCLES, 1000, idle clk cycles between the end of one frame and the next snapshot (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_en  in  1  link enable; frames start only while high
tx_full  in  1  UART TX FIFO full flag
local_shooter  in  1  this board is the shooter (peer sees enemy_shooter=1)
game_starts  in  1  game in progress
keeper_pos  in  10  local keeper glove position
x_shooter  in  10  local shot x
y_shooter  in  10  local shot y
score  in  3  local score
is_shooted  in  1  local shot finished
wr_uart  out  1  one-cycle FIFO write strobe
w_data  out  8  byte to FIFO, valid when wr_uart=1
frame_done  out  1  one-cycle pulse in the cycle after the 8th byte is written

Behaviour:
- Reset: wr_uart=0, w_data=8'h00, frame_done=0, state=GAP, gap counter=0, byte index=0, snapshot registers=0. All outputs are registered.
- States:
  - GAP: counts up to GAP_CYCLES-1. At terminal count, if tx_en=1 -> SNAP. If tx_en=0, holds at terminal count.
  - SNAP: 1 cycle. Latches all inputs into snapshot registers, sets index=0 -> SEND.
  - SEND: emits bytes index 0..7 from the snapshot only; inputs changing mid-frame do not affect the frame.
- Byte format: {payload[4:0], opcode[2:0]}, opcode = index.
  - 0: payload = {local_shooter & game_starts, game_starts, 3'b001}. Sender never emits 10001.
  - 1: keeper_pos[4:0]
  - 2: keeper_pos[9:5]
  - 3: x_shooter[4:0]
  - 4: x_shooter[9:5]
  - 5: y_shooter[4:0]
  - 6: y_shooter[9:5]
  - 7: payload = {1'b0, is_shooted, score[2:0]}
- Handshake:
  - In SEND, a write is issued in cycle N+1 only if tx_full=0 at cycle N and wr_uart=0 at cycle N. Writes are therefore never back-to-back; max rate is 1 byte per 2 cycles, so a frame takes >=16 cycles.
  - While tx_full=1, hold index and keep wr_uart=0. No byte is dropped or duplicated.
  - Index increments in the write cycle.
- After the write of index 7: frame_done=1 for the next cycle; gap counter cleared -> GAP.
- tx_en falling mid-frame: the frame is completed, then the block waits in GAP.
- rst mid-frame: immediate return to reset values. The partial frame is abandoned and the next frame restarts at opcode 0.
- w_data holds its last value while wr_uart=0.

Optional Feature:
- Macro: UART_ENC_SHOT_PRIORITY_EN.
- Defined: a 0->1 edge of is_shooted (registered edge detect) during GAP with tx_en=1 forces GAP -> SNAP in the next cycle, regardless of the gap count.
  - An edge during SNAP/SEND is latched and triggers an immediate frame after the current one, skipping GAP.
  - The pending flag clears on SNAP and on rst.
- Undefined: is_shooted is sampled only at SNAP; frame timing is purely GAP_CYCLES-driven.

Test Plan:
- GAP_CYCLES=4, tx_en=1, tx_full=0, local_shooter=1, game_starts=1, keeper_pos=10'h2A5, x=640, y=480, score=3, is_shooted=1 -> bytes C8,29,AA,03,A4,05,7E,5F in order; wr_uart alternates 1/0; frame_done one cycle after 5F.
- local_shooter=1, game_starts=0 -> byte 0 = 8'h08 (never 8'h88).
- tx_full held 1 for 10 cycles after byte 2 -> no wr_uart during stall; byte 3 (03) issued 1 cycle after tx_full drops; 8 bytes total, no repeats.
- Change keeper_pos to 10'h000 between bytes 1 and 2 -> byte 2 still AA (snapshot coherence).
- Assert rst after byte 4, release -> outputs 0; next frame begins with opcode 0 after GAP_CYCLES; tx_en=0 -> no writes at all.
- With UART_ENC_SHOT_PRIORITY_EN, GAP_CYCLES=1000, is_shooted 0->1 at gap count 10 -> SNAP within 2 cycles, byte 7 = 5F; without the macro, next frame starts at count 999.
